// File: rtl/regbank_wb_if.sv
// ---------------------------------------------------------------------------
// regbank_wb_if
//   Issue/write-back handshake bundle for regbank_wb.
//   Reservation channel : rsv_valid, rsv_addr  -> rsv_ready
//   Write-back channel  : wb_valid, wb_addr, wb_data -> wb_ready
//   Retire control      : freeze (1 = hold the write-back queue)
//   master modport = issue/execute side, slave modport = register bank.
// ---------------------------------------------------------------------------
interface regbank_wb_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
);
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              freeze;

    modport master (
        output rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data, freeze,
        input  rsv_ready, wb_ready
    );

    modport slave (
        input  rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data, freeze,
        output rsv_ready, wb_ready
    );
endinterface

// File: rtl/regbank_wb.sv
// ---------------------------------------------------------------------------
// regbank_wb
//   Eight-entry register bank with a per-register busy scoreboard and a
//   small in-order write-back FIFO. Issue reserves a destination register;
//   write-back entries are queued and retired one per clock, in order.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     bus (slave)     reservation / write-back handshake + freeze
//     reg0_q..reg7_q  registered register contents (operand mux inputs)
//     busy            pending bitmap, bit i = register i
//     wr_commit       registered pulse: an entry retired on the last edge
//     err             sticky: a retire hit a register that was not busy
// ---------------------------------------------------------------------------
module regbank_wb #(
    parameter int DATA_W = 10,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    regbank_wb_if.slave       bus,
    output logic [DATA_W-1:0] reg0_q,
    output logic [DATA_W-1:0] reg1_q,
    output logic [DATA_W-1:0] reg2_q,
    output logic [DATA_W-1:0] reg3_q,
    output logic [DATA_W-1:0] reg4_q,
    output logic [DATA_W-1:0] reg5_q,
    output logic [DATA_W-1:0] reg6_q,
    output logic [DATA_W-1:0] reg7_q,
    output logic [NREG-1:0]   busy,
    output logic              wr_commit,
    output logic              err
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             busy_q, busy_d;
    wb_ent_t [QDEPTH-1:0]        fifo_q, fifo_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        commit_q, commit_d;
    logic                        err_q, err_d;

    logic    enq, deq;
    wb_ent_t head;

    assign bus.rsv_ready = !busy_q[bus.rsv_addr];
    assign bus.wb_ready  = (cnt_q < CNT_W'(QDEPTH));

    // Acceptance looks only at the registered count: a retire on the same
    // edge does not open a slot for a full queue.
    assign enq  = bus.wb_valid && bus.wb_ready;
    assign deq  = (cnt_q != '0) && !bus.freeze;
    assign head = fifo_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        err_d    = err_q;

        if (deq) begin
            regs_d[head.addr] = head.data;
            busy_d[head.addr] = 1'b0;
            commit_d          = 1'b1;
            if (!busy_q[head.addr])
                err_d = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Applied after the retire clear: a reservation granted on the same
        // edge belongs to a newer instruction and must survive.
        if (bus.rsv_valid && bus.rsv_ready)
            busy_d[bus.rsv_addr] = 1'b1;

        if (enq) begin
            fifo_d[wr_ptr_q] = '{addr: bus.wb_addr, data: bus.wb_data};
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end

        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            busy_q   <= '0;
            fifo_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign reg0_q    = regs_q[0];
    assign reg1_q    = regs_q[1];
    assign reg2_q    = regs_q[2];
    assign reg3_q    = regs_q[3];
    assign reg4_q    = regs_q[4];
    assign reg5_q    = regs_q[5];
    assign reg6_q    = regs_q[6];
    assign reg7_q    = regs_q[7];
    assign busy      = busy_q;
    assign wr_commit = commit_q;
    assign err       = err_q;
endmodule
